// File: rtl/endpoint_fifo_if.sv
// Handshake bundle between an endpoint FIFO and its producer/consumer.
// master drives writes/reads and commit controls; slave is the FIFO.
interface endpoint_fifo_if #(
  parameter int unsigned DEPTH = 64,
  parameter int unsigned WIDTH = 8
);
  localparam int unsigned AW = $clog2(DEPTH);

  logic [WIDTH-1:0] data;
  logic             wrreq;
  logic             wr_commit;
  logic             wr_rollback;
  logic [WIDTH-1:0] q;
  logic             rdreq;
  logic             rd_commit;
  logic             rd_rollback;
  logic             full;
  logic             empty;
  logic [AW:0]      count;

  modport master (
    output data, wrreq, wr_commit, wr_rollback, rdreq, rd_commit, rd_rollback,
    input  q, full, empty, count
  );

  modport slave (
    input  data, wrreq, wr_commit, wr_rollback, rdreq, rd_commit, rd_rollback,
    output q, full, empty, count
  );
endinterface

// File: rtl/endpoint_fifo.sv
// Byte FIFO with packet commit/rollback on both write and read sides.
// Committed/tentative boundaries are kept as separate base/next pointers per side.
module endpoint_fifo #(
  parameter int unsigned DEPTH = 64,
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  endpoint_fifo_if.slave   bus
);
  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned PW = AW + 1;

  logic [PW-1:0]    wr_ptr, wr_base, rd_ptr, rd_base;
  logic [PW-1:0]    wr_ptr_nxt, wr_base_nxt, rd_ptr_nxt, rd_base_nxt;
  logic             full_c, empty_c, wr_accept_c, rd_accept_c;
  logic [WIDTH-1:0] mem [DEPTH];

  // Read-but-uncommitted entries still occupy space, so full is measured from rd_base
  always_comb begin
    full_c      = (wr_ptr - rd_base) == PW'(DEPTH);
    empty_c     = (rd_ptr == wr_base);
    wr_accept_c = bus.wrreq & ~full_c & ~bus.wr_rollback;
    rd_accept_c = bus.rdreq & ~empty_c & ~bus.rd_rollback;
  end

  // Write side: rollback beats commit beats plain write
  always_comb begin
    wr_ptr_nxt  = wr_ptr;
    wr_base_nxt = wr_base;
    if (bus.wr_rollback) begin
      wr_ptr_nxt = wr_base;
    end else begin
      if (wr_accept_c) wr_ptr_nxt = wr_ptr + PW'(1);
      if (bus.wr_commit) wr_base_nxt = wr_ptr + PW'(wr_accept_c);
    end
  end

  // Read side mirrors the write side
  always_comb begin
    rd_ptr_nxt  = rd_ptr;
    rd_base_nxt = rd_base;
    if (bus.rd_rollback) begin
      rd_ptr_nxt = rd_base;
    end else begin
      if (rd_accept_c) rd_ptr_nxt = rd_ptr + PW'(1);
      if (bus.rd_commit) rd_base_nxt = rd_ptr + PW'(rd_accept_c);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr  <= '0;
      wr_base <= '0;
      rd_ptr  <= '0;
      rd_base <= '0;
    end else begin
      wr_ptr  <= wr_ptr_nxt;
      wr_base <= wr_base_nxt;
      rd_ptr  <= rd_ptr_nxt;
      rd_base <= rd_base_nxt;
    end
  end

  // Storage is not reset; contents are only observable behind committed pointers
  always_ff @(posedge clk) begin
    if (wr_accept_c) mem[wr_ptr[AW-1:0]] <= bus.data;
  end

  assign bus.q     = mem[rd_ptr[AW-1:0]];
  assign bus.full  = full_c;
  assign bus.empty = empty_c;
  assign bus.count = wr_base - rd_ptr;
endmodule

// File: tb/tb_endpoint_fifo.sv
// Self-checking bench for endpoint_fifo: directed vector table, hand sequences,
// and a random packet stress run against a queue-based packet model.
module tb_endpoint_fifo;
  localparam int unsigned DEPTH = 64;
  localparam int unsigned WIDTH = 8;

  logic clk = 1'b0;
  logic reset;
  int   checks = 0;
  int   failures = 0;

  always #5 clk = ~clk;

  endpoint_fifo_if #(.DEPTH(DEPTH), .WIDTH(WIDTH)) intf ();

  endpoint_fifo #(.DEPTH(DEPTH), .WIDTH(WIDTH)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (intf)
  );

  // Model: tentative writes, committed-unread bytes, read-but-uncommitted bytes
  logic [7:0] wq[$];
  logic [7:0] cq[$];
  logic [7:0] rq[$];

  typedef struct {
    logic [7:0] d;
    logic       wr, wc, wrb, rd, rc, rrb;
    logic       e_empty;
    logic       e_full;
    int         e_count;
    logic [7:0] e_q;
  } vec_t;

  vec_t vt[22];

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic void model_reset();
    wq.delete();
    cq.delete();
    rq.delete();
  endfunction

  function automatic int model_occ();
    return wq.size() + cq.size() + rq.size();
  endfunction

  function automatic void model_step(input logic [7:0] d, input logic wr, wc, wrb,
                                     input logic rd, rc, rrb);
    logic wacc, racc;
    wacc = wr && (model_occ() < int'(DEPTH)) && !wrb;
    racc = rd && (cq.size() > 0) && !rrb;
    if (rrb) begin
      for (int i = rq.size() - 1; i >= 0; i--) cq.push_front(rq[i]);
      rq.delete();
    end else begin
      if (racc) rq.push_back(cq.pop_front());
      if (rc) rq.delete();
    end
    if (wrb) begin
      wq.delete();
    end else begin
      if (wacc) wq.push_back(d);
      if (wc) begin
        foreach (wq[i]) cq.push_back(wq[i]);
        wq.delete();
      end
    end
  endfunction

  task automatic check_model(input string tag);
    chk({tag, ".empty"}, int'(intf.empty), int'(cq.size() == 0));
    chk({tag, ".full"},  int'(intf.full),  int'(model_occ() == int'(DEPTH)));
    chk({tag, ".count"}, int'(intf.count), cq.size());
    if (cq.size() > 0) chk({tag, ".q"}, int'(intf.q), int'(cq[0]));
  endtask

  task automatic drive(input logic [7:0] d, input logic wr, wc, wrb,
                       input logic rd, rc, rrb);
    intf.data        = d;
    intf.wrreq       = wr;
    intf.wr_commit   = wc;
    intf.wr_rollback = wrb;
    intf.rdreq       = rd;
    intf.rd_commit   = rc;
    intf.rd_rollback = rrb;
  endtask

  task automatic cyc(input logic [7:0] d, input logic wr, wc, wrb,
                     input logic rd, rc, rrb);
    drive(d, wr, wc, wrb, rd, rc, rrb);
    model_step(d, wr, wc, wrb, rd, rc, rrb);
    @(posedge clk);
    #1;
  endtask

  initial begin
    int pk, left, guard;
    logic wr, wc, wrb, rd, rc, rrb;

    // d, wr, wc, wrb, rd, rc, rrb, empty, full, count, q
    vt[0]  = '{8'hA0, 1, 0, 0, 0, 0, 0, 1, 0, 0, 8'h00};
    vt[1]  = '{8'hA1, 1, 0, 0, 0, 0, 0, 1, 0, 0, 8'h00};
    vt[2]  = '{8'hA2, 1, 0, 0, 0, 0, 0, 1, 0, 0, 8'h00};
    vt[3]  = '{8'hA3, 1, 0, 0, 0, 0, 0, 1, 0, 0, 8'h00};
    vt[4]  = '{8'hA4, 1, 0, 0, 0, 0, 0, 1, 0, 0, 8'h00};
    vt[5]  = '{8'hEE, 1, 0, 1, 0, 0, 0, 1, 0, 0, 8'h00};
    vt[6]  = '{8'h55, 1, 1, 0, 0, 0, 0, 0, 0, 1, 8'h55};
    vt[7]  = '{8'h00, 0, 0, 0, 1, 1, 0, 1, 0, 0, 8'h00};
    vt[8]  = '{8'h10, 1, 1, 0, 0, 0, 0, 0, 0, 1, 8'h10};
    vt[9]  = '{8'h11, 1, 1, 0, 0, 0, 0, 0, 0, 2, 8'h10};
    vt[10] = '{8'h12, 1, 1, 0, 0, 0, 0, 0, 0, 3, 8'h10};
    vt[11] = '{8'h00, 0, 0, 0, 1, 0, 0, 0, 0, 2, 8'h11};
    vt[12] = '{8'h00, 0, 0, 0, 1, 0, 0, 0, 0, 1, 8'h12};
    vt[13] = '{8'h00, 0, 0, 0, 1, 0, 0, 1, 0, 0, 8'h00};
    vt[14] = '{8'h00, 0, 0, 0, 1, 0, 1, 0, 0, 3, 8'h10};
    vt[15] = '{8'h00, 0, 0, 0, 1, 0, 0, 0, 0, 2, 8'h11};
    vt[16] = '{8'h00, 0, 0, 0, 1, 1, 0, 0, 0, 1, 8'h12};
    vt[17] = '{8'h00, 0, 0, 0, 1, 1, 0, 1, 0, 0, 8'h00};
    vt[18] = '{8'h77, 1, 1, 0, 1, 0, 1, 0, 0, 1, 8'h77};
    vt[19] = '{8'h88, 1, 0, 0, 1, 1, 0, 1, 0, 0, 8'h00};
    vt[20] = '{8'h99, 1, 0, 1, 0, 0, 0, 1, 0, 0, 8'h00};
    vt[21] = '{8'h00, 0, 1, 0, 0, 0, 0, 1, 0, 0, 8'h00};

    drive(8'h00, 0, 0, 0, 0, 0, 0);
    reset = 1'b1;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    chk("reset.empty", int'(intf.empty), 1);
    chk("reset.full",  int'(intf.full),  0);
    chk("reset.count", int'(intf.count), 0);

    foreach (vt[i]) begin
      cyc(vt[i].d, vt[i].wr, vt[i].wc, vt[i].wrb, vt[i].rd, vt[i].rc, vt[i].rrb);
      chk($sformatf("vec%0d.empty", i), int'(intf.empty), int'(vt[i].e_empty));
      chk($sformatf("vec%0d.full", i),  int'(intf.full),  int'(vt[i].e_full));
      chk($sformatf("vec%0d.count", i), int'(intf.count), vt[i].e_count);
      if (vt[i].e_count > 0) chk($sformatf("vec%0d.q", i), int'(intf.q), int'(vt[i].e_q));
    end

    // Plain FIFO fill to DEPTH, overflow attempt, replay, drain
    for (int i = 1; i <= int'(DEPTH); i++) begin
      cyc(8'(i), 1, 1, 0, 0, 1, 0);
      check_model($sformatf("fill%0d", i));
    end
    chk("fill.full",  int'(intf.full),  1);
    chk("fill.count", int'(intf.count), 64);
    cyc(8'hFF, 1, 1, 0, 0, 1, 0);
    chk("over.full",  int'(intf.full),  1);
    chk("over.count", int'(intf.count), 64);
    cyc(8'h00, 0, 0, 0, 1, 0, 0);
    chk("rdonly.full",  int'(intf.full),  1);
    chk("rdonly.count", int'(intf.count), 63);
    cyc(8'h00, 0, 0, 0, 0, 0, 1);
    chk("replay.count", int'(intf.count), 64);
    chk("replay.q",     int'(intf.q),     1);
    for (int i = 1; i <= int'(DEPTH); i++) begin
      chk($sformatf("drain%0d.q", i), int'(intf.q), i);
      cyc(8'h00, 0, 0, 0, 1, 1, 0);
      check_model($sformatf("drain%0d", i));
    end
    chk("drain.empty", int'(intf.empty), 1);
    chk("drain.full",  int'(intf.full),  0);

    // Random packets with commit/rollback on both sides
    pk = 0;
    left = 0;
    guard = 0;
    while (pk < 1000 && guard < 60000) begin
      guard++;
      if (left == 0) left = int'($urandom_range(1, 20));
      wr  = ($urandom % 4) != 0;
      wc  = 1'b0;
      wrb = 1'b0;
      if (wr) begin
        left--;
        if (left == 0) begin
          pk++;
          if (($urandom % 5) == 0) wrb = 1'b1;
          else wc = 1'b1;
        end
      end
      rd  = ($urandom % 4) != 0;
      rc  = ($urandom % 3) == 0;
      rrb = ($urandom % 16) == 0;
      cyc(8'($urandom), wr, wc, wrb, rd, rc, rrb);
      check_model("stress");
    end
    chk("stress.packets", pk, 1000);

    // Reset mid-packet: committed data, tentative writes and tentative reads all lost
    cyc(8'h00, 0, 0, 0, 0, 0, 1);
    cyc(8'h00, 0, 0, 0, 0, 0, 0);
    reset = 1'b1;
    model_reset();
    @(posedge clk);
    #1;
    reset = 1'b0;
    cyc(8'hC0, 1, 1, 0, 0, 0, 0);
    cyc(8'hC1, 1, 1, 0, 0, 0, 0);
    cyc(8'hD0, 1, 0, 0, 0, 0, 0);
    cyc(8'hD1, 1, 0, 0, 1, 0, 0);
    cyc(8'hD2, 1, 0, 0, 1, 0, 0);
    check_model("prereset");
    chk("prereset.full", int'(intf.full), 0);
    #1;
    reset = 1'b1;
    model_reset();
    #2;
    chk("asyncrst.empty", int'(intf.empty), 1);
    chk("asyncrst.full",  int'(intf.full),  0);
    chk("asyncrst.count", int'(intf.count), 0);
    drive(8'h00, 0, 0, 0, 0, 0, 0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    cyc(8'hE1, 1, 1, 0, 0, 0, 0);
    check_model("postreset");
    chk("postreset.q", int'(intf.q), 8'hE1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/endpoint_fifo.md
# endpoint_fifo

Byte FIFO with packet-level commit/rollback on both sides, one instance per USB endpoint. Sits between the USB serial interface engine (SIE) and the J1 I/O register decoder. OUT endpoints: SIE writes, J1 reads. IN endpoints: J1 writes, SIE reads. Rollback lets the SIE discard a packet with a bad CRC (write side) or replay an unacknowledged IN packet (read side). Tying both commit inputs high and both rollback inputs low gives a plain show-ahead FIFO.

## Interface
- DEPTH, 64, entries; power of two, 4..1024
- WIDTH, 8, data bits
- clk  in  1  single clock for all logic
- reset  in  1  asynchronous, active-high
- data  in  WIDTH  write data
- wrreq  in  1  write one entry this cycle
- wr_commit  in  1  publish all tentative writes to the reader
- wr_rollback  in  1  discard all uncommitted writes
- q  out  WIDTH  show-ahead read data; valid when empty=0
- rdreq  in  1  pop the entry on q this cycle
- rd_commit  in  1  free all tentatively read entries
- rd_rollback  in  1  rewind reader to last committed read position
- full  out  1  no free entry for a write
- empty  out  1  no committed, unread entry
- count  out  $clog2(DEPTH)+1  committed entries not yet read

## Operation
- AW = $clog2(DEPTH). Four pointers, each AW+1 bits, wrapping modulo 2·DEPTH:
  - wr_ptr: next write position
  - wr_base: committed write position
  - rd_ptr: next read position
  - rd_base: committed read position
- Storage: DEPTH×WIDTH array, indexed by pointer[AW-1:0]. Written on accepted wrreq. q = mem[rd_ptr[AW-1:0]], combinational read.
- full = (wr_ptr − rd_base == DEPTH). Entries read but not committed stay occupied.
- empty = (rd_ptr == wr_base). Uncommitted writes are invisible to the reader.
- count = wr_base − rd_ptr.
- Write side, per cycle, first matching rule wins:
  - wr_rollback: wr_ptr ← wr_base. A wrreq in the same cycle is dropped. A wr_commit in the same cycle is ignored.
  - wr_commit: wr_base ← wr_ptr + (accepted wrreq ? 1 : 0). The same-cycle byte is included in the commit.
  - Accepted wrreq: wr_ptr ← wr_ptr + 1.
- wrreq while full: ignored; no pointer or memory change.
- Read side, symmetric:
  - rd_rollback: rd_ptr ← rd_base; a same-cycle rdreq is dropped.
  - rd_commit: rd_base ← rd_ptr + (accepted rdreq ? 1 : 0).
  - Accepted rdreq: rd_ptr ← rd_ptr + 1.
- rdreq while empty: ignored.
- Write and read sides are independent; all combinations in one cycle are legal.
- Reset: all pointers 0, memory contents undefined. Outputs: empty=1, full=0, count=0, q undefined.

## Timing
- Every output is a function of registered pointers. Flags change only on the cycle after the causing clock edge.
- Write to read visibility: data is written at edge N with wr_commit asserted. empty falls and q is valid after edge N; the reader may pop in cycle N+1.
- Without wr_commit, the written byte never becomes visible.
- Read freeing: full falls one cycle after the edge where rd_commit frees space. Reads alone never clear full.
- Pop: at the edge with rdreq, q advances to the next entry.
- Back-to-back: one write and one read per cycle sustained, no bubbles, with both commits held high.
- Wrap-around: pointer MSB distinguishes full from empty. Correct across any number of wraps.
- Reset mid-packet: all tentative and committed state is lost. Outputs return to reset values asynchronously.

## Test plan
- Plain FIFO, commits tied high, rollbacks low. Write 0x01..0x40 (DEPTH=64) → full=1 after the 64th write, count=64. 65th write ignored. Read back 0x01..0x40 in order, then empty=1.
- Write rollback. Write 0xA0..0xA4 uncommitted → empty stays 1. Assert wr_rollback, then write 0x55 with commit → count=1, q=0x55.
- Read replay. Commit 0x10,0x11,0x12. Read all three with no rd_commit → empty=1, full computed against rd_base. rd_rollback → count=3, q=0x10. Read again, then rd_commit frees the entries.
- Simultaneous events. wrreq+wr_commit in one cycle → byte included, count +1 next cycle. wrreq+wr_rollback → byte dropped. rdreq+rd_rollback → rd_ptr = rd_base.
- Wrap stress. 1000 random packets of 1..20 bytes with random commit/rollback against a reference model → q, count, full and empty match every cycle.
- Reset mid-packet. Assert reset after 3 uncommitted writes and 2 uncommitted reads → empty=1, full=0, count=0 immediately, without waiting for a clock edge.
